enemy_fire_arbiter: RTL and testbench
=====================================

# enemy_fire_arbiter

Shares the single enemy-bullet resource among the five enemies of a wave. Enemies raise fire requests; the block grants at most one shot at a time in round-robin order, only to live enemies, and only when no enemy bullet is in flight. Grants are rate-limited by a level-dependent cooldown. All grants are suppressed during the level-up transition. The block sits between the enemy controllers and the enemy-bullet mover. It consumes `level` and `level_up_out` from the level logic.

## Interface
- `N_EN`, 5: number of enemies (requesters).
- `CD_BASE`, 40_000_000: cooldown in pclk cycles at level 1.
- `CD_STEP`, 2_000_000: cooldown reduction per level above 1.
- `CD_MIN`, 8_000_000: cooldown floor.
- `ACK_TO`, 16: cycles to wait for `bullet_busy` after a grant.
- `pclk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `level` in 4: current level; a value of 0 is treated as 1.
- `level_up` in 1: high while the level transition is in progress.
- `alive` in N_EN: bit i is the lives flag of enemy i.
- `fire_req` in N_EN: bit i is high while enemy i wants to shoot (level-sensitive).
- `bullet_busy` in 1: high while an enemy bullet is in flight.
- `fire_grant` out N_EN: one-hot grant pulse, one cycle wide.
- `grant_id` out 3: index of the last granted enemy; holds its value between grants.
- `armed` out 1: high in READY.

## Operation
- Eligible requests: `elig = fire_req & alive`.
- States:
  - HOLD: level_up active.
  - COOL: cooldown counting.
  - READY: waiting for an eligible request.
  - ACK: waiting for the bullet to launch.
  - FLIGHT: waiting for the bullet to finish.
- Reset: state COOL, counter 0, `cd_limit` = CD_BASE, round-robin pointer `rr` = 0. Outputs: `fire_grant` = 0, `grant_id` = 0, `armed` = 0.
- `level_up` = 1 in any state moves to HOLD on the next edge. This has priority over every other transition.
- HOLD:
  - Counter and `rr` are cleared.
  - When `level_up` falls, go to COOL and latch `cd_limit` from the current `level`.
- Cooldown limit: `cd_limit = max(CD_BASE − (L−1)·CD_STEP, CD_MIN)`, with L = max(level, 1).
  - Compute in 32-bit unsigned arithmetic.
  - Clamp on underflow: if (L−1)·CD_STEP ≥ CD_BASE − CD_MIN, the result is CD_MIN.
- `cd_limit` is latched on every entry to COOL, so a level change during cooldown takes effect on the next cooldown.
- COOL:
  - Counter increments each cycle.
  - When counter = `cd_limit` − 1, clear the counter and go to READY.
- READY:
  - If `elig` ≠ 0 and `bullet_busy` = 0: choose the first set bit of `elig` searching from index `rr` upward, wrapping modulo N_EN.
  - Assert that bit on `fire_grant` for one cycle and load `grant_id` with its index.
  - Set `rr` = index+1 mod N_EN and go to ACK.
  - Otherwise stay in READY.
- ACK:
  - Counter increments.
  - `bullet_busy` = 1 moves to FLIGHT.
  - Counter reaching ACK_TO−1 without busy moves to COOL (grant lost; no retry).
- FLIGHT: `bullet_busy` = 0 moves to COOL.
- Enemy dying in flight: the flight still completes normally.
- All enemies dead: READY idles forever and no grant is issued.
- A request that drops before READY samples it is never granted. There is no request latching.

## Timing
- Registered outputs only; there are no combinational paths from inputs to outputs.
- Grant latency: `elig` sampled at edge k in READY gives `fire_grant` high during cycle k+1 only.
- `armed` is high exactly in the cycles the state is READY.
- Minimum spacing between two grants is `cd_limit` + 3 cycles: grant, at least 1 ACK cycle, at least 1 FLIGHT cycle, cooldown.
- `level_up` asserted on the same edge as a READY grant decision: HOLD wins and no grant is issued.
- `rst_n` low mid-operation immediately clears `fire_grant` to 0, asynchronously. Operation restarts in COOL with `cd_limit` = CD_BASE.

## Structure
- Shared game package holds the state encoding (HOLD/COOL/READY/ACK/FLIGHT), N_EN, and the default cooldown constants. The level module and the bullet mover reuse those constants.
- One sub-module: `rr_pick`, a combinational round-robin priority picker.
  - Inputs: `req[N_EN]`, `ptr`.
  - Outputs: one-hot `gnt`, index `idx`, `any`.
- The FSM, counter, and `cd_limit` logic live in the top.

## Test plan
Benches use CD_BASE=20, CD_STEP=4, CD_MIN=8, ACK_TO=4.
1. Reset, then level=1 with `fire_req`=5'b00001, `alive`=all, and the bullet model asserting busy 1 cycle after each grant for 3 cycles → first grant to enemy 0, 21 cycles after reset release, then every 26 cycles.
2. `fire_req`=all, `alive`=all → grant_id sequence 0,1,2,3,4,0.
3. `alive`=5'b10101, `fire_req`=all → grant_id sequence 0,2,4,0; enemies 1 and 3 are never granted.
4. Levels 1, 3, 5, 9 → READY reached after 20, 12, 8, 8 COOL cycles (clamping at level 5 and above); level=0 behaves as level 1.
5. `bullet_busy` never asserts → ACK times out after 4 cycles and returns to COOL. `bullet_busy` held high in READY → no grant until it falls.
6. `level_up` pulsed for 10 cycles during FLIGHT → HOLD with no grants and `rr` cleared. After the fall, the next grant goes to the lowest-index eligible enemy. Asserting `rst_n` low mid-grant clears `fire_grant` in the same cycle.

Source files
------------

// File: rtl/enemy_fire_arbiter_pkg.sv
// Shared enemy-fire constants, arbiter state encoding and the
// level-to-cooldown helper used by level logic and bullet mover.
package enemy_fire_arbiter_pkg;

  localparam int N_EN  = 5;
  localparam int IDX_W = 3;

  localparam logic [31:0] CD_BASE_DEF = 32'd40_000_000;
  localparam logic [31:0] CD_STEP_DEF = 32'd2_000_000;
  localparam logic [31:0] CD_MIN_DEF  = 32'd8_000_000;
  localparam int          ACK_TO_DEF  = 16;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_COOL,
    ST_READY,
    ST_ACK,
    ST_FLIGHT
  } fire_st_e;

  // Level 0 counts as level 1; the decrement saturates at the floor.
  function automatic logic [31:0] cd_calc(
    input logic [3:0]  lvl,
    input logic [31:0] base,
    input logic [31:0] step,
    input logic [31:0] min_v
  );
    logic [31:0] l;
    logic [31:0] dec;
    l   = (lvl == 4'd0) ? 32'd1 : {28'd0, lvl};
    dec = (l - 32'd1) * step;
    if (dec >= base - min_v) begin
      return min_v;
    end
    return base - dec;
  endfunction

endpackage

// File: rtl/enemy_fire_arbiter_if.sv
// Enemy fire bundle: requests and lives from the enemy controllers,
// bullet status from the mover, grants back out.
interface enemy_fire_arbiter_if;
  import enemy_fire_arbiter_pkg::*;

  logic [N_EN-1:0]  fire_req;
  logic [N_EN-1:0]  alive;
  logic             bullet_busy;
  logic [N_EN-1:0]  fire_grant;
  logic [IDX_W-1:0] grant_id;
  logic             armed;

  modport master (
    output fire_req,
    output alive,
    output bullet_busy,
    input  fire_grant,
    input  grant_id,
    input  armed
  );

  modport slave (
    input  fire_req,
    input  alive,
    input  bullet_busy,
    output fire_grant,
    output grant_id,
    output armed
  );

endinterface

// File: rtl/enemy_fire_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or
// above ptr, wrapping modulo N_EN.
module rr_pick
  import enemy_fire_arbiter_pkg::*;
(
  input  logic [N_EN-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_EN-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] p;

  // Walk offsets high to low so the nearest hit overwrites the rest.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    p   = '0;
    for (int k = N_EN - 1; k >= 0; k--) begin
      p = IDX_W'((int'(ptr) + k) % N_EN);
      if (req[p]) begin
        any = 1'b1;
        idx = p;
      end
    end
    if (any) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/enemy_fire_arbiter.sv
// Enemy bullet arbiter: round-robin single-shot grants to live
// enemies, gated by bullet status, cooldown and level transitions.
module enemy_fire_arbiter
  import enemy_fire_arbiter_pkg::*;
#(
  parameter logic [31:0] CD_BASE = CD_BASE_DEF,
  parameter logic [31:0] CD_STEP = CD_STEP_DEF,
  parameter logic [31:0] CD_MIN  = CD_MIN_DEF,
  parameter int          ACK_TO  = ACK_TO_DEF
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic [3:0] level,
  input  logic       level_up,
  enemy_fire_arbiter_if.slave arb
);

  localparam logic [31:0] ACK_LAST = 32'(ACK_TO - 1);

  fire_st_e         state_q;
  fire_st_e         state_d;
  logic [31:0]      cnt_q;
  logic [31:0]      cnt_d;
  logic [31:0]      cd_q;
  logic [31:0]      cd_d;
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] rr_d;
  logic [N_EN-1:0]  gnt_q;
  logic [N_EN-1:0]  gnt_d;
  logic [IDX_W-1:0] gid_q;
  logic [IDX_W-1:0] gid_d;
  logic             armed_q;

  logic [N_EN-1:0]  elig;
  logic [N_EN-1:0]  pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [31:0]      cd_new;
  logic [IDX_W-1:0] rr_next;

  assign elig   = arb.fire_req & arb.alive;
  assign cd_new = cd_calc(level, CD_BASE, CD_STEP, CD_MIN);

  assign rr_next = (pick_idx == IDX_W'(N_EN - 1)) ?
                   '0 : pick_idx + IDX_W'(1);

  rr_pick u_pick (
    .req (elig),
    .ptr (rr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cd_d    = cd_q;
    rr_d    = rr_q;
    gnt_d   = '0;
    gid_d   = gid_q;
    case (state_q)
      ST_HOLD: begin
        cnt_d = '0;
        rr_d  = '0;
        if (!level_up) begin
          state_d = ST_COOL;
          cd_d    = cd_new;
        end
      end
      ST_COOL: begin
        if (cnt_q == cd_q - 32'd1) begin
          cnt_d   = '0;
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_READY: begin
        if (pick_any && !arb.bullet_busy) begin
          gnt_d   = pick_gnt;
          gid_d   = pick_idx;
          rr_d    = rr_next;
          cnt_d   = '0;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        // A launch seen on the last wait cycle still counts.
        if (arb.bullet_busy) begin
          cnt_d   = '0;
          state_d = ST_FLIGHT;
        end else if (cnt_q == ACK_LAST) begin
          cnt_d   = '0;
          cd_d    = cd_new;
          state_d = ST_COOL;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_FLIGHT: begin
        if (!arb.bullet_busy) begin
          cnt_d   = '0;
          cd_d    = cd_new;
          state_d = ST_COOL;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_COOL;
      end
    endcase
    if (level_up) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      cd_d    = cd_q;
      rr_d    = '0;
      gnt_d   = '0;
      gid_d   = gid_q;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COOL;
      cnt_q   <= '0;
      cd_q    <= CD_BASE;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cd_q    <= cd_d;
      rr_q    <= rr_d;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      gid_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      gid_q   <= gid_d;
      armed_q <= (state_d == ST_READY);
    end
  end

  assign arb.fire_grant = gnt_q;
  assign arb.grant_id   = gid_q;
  assign arb.armed      = armed_q;

endmodule

// File: tb/tb_enemy_fire_arbiter.sv
// Randomized scoreboard bench for enemy_fire_arbiter using a
// timeline model of grants, bullet flights and cooldowns.
module tb_enemy_fire_arbiter;
  import enemy_fire_arbiter_pkg::*;

  localparam int CB    = 20;
  localparam int CS    = 4;
  localparam int CM    = 8;
  localparam int AT    = 4;
  localparam int NEVER = 32'h3fff_ffff;

  typedef struct {
    int cyc;
    int idx;
  } exp_t;

  logic       pclk     = 1'b0;
  logic       rst_n    = 1'b0;
  logic [3:0] level    = 4'd1;
  logic       level_up = 1'b0;

  enemy_fire_arbiter_if bus ();

  enemy_fire_arbiter #(
    .CD_BASE (32'(CB)),
    .CD_STEP (32'(CS)),
    .CD_MIN  (32'(CM)),
    .ACK_TO  (AT)
  ) dut (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .level    (level),
    .level_up (level_up),
    .arb      (bus)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int   n_chk   = 0;
  int   n_pass  = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   exp_gid = 0;

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d want %0d at cycle %0d",
                  nm, act, req, cyc);
  endtask

  // Cooldown length from the level rule, done in signed arithmetic.
  function automatic int cd_of(input logic [3:0] lv);
    int l;
    int v;
    l = (lv == 4'd0) ? 1 : int'(lv);
    v = CB - (l - 1) * CS;
    return (v < CM) ? CM : v;
  endfunction

  function automatic int pick(input logic [4:0] el, input int from);
    logic [4:0] t;
    for (int k = 0; k < N_EN; k++) begin
      t = el >> ((from + k) % N_EN);
      if (t[0]) return (from + k) % N_EN;
    end
    return 0;
  endfunction

  // Monitor: every presented grant must match the queue head.
  always @(negedge pclk) begin
    if (rst_n) begin
      if (bus.fire_grant != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_grant", int'(bus.fire_grant), 0);
        end else begin
          mon_e = sb.pop_front();
          check("grant_cycle", cyc, mon_e.cyc);
          check("grant_onehot", int'(bus.fire_grant), 1 << mon_e.idx);
          exp_gid = mon_e.idx;
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        mon_e = sb.pop_front();
        check("grant_missing", 0, 1 << mon_e.idx);
      end
      check("grant_id", int'(bus.grant_id), exp_gid);
    end
  end

  int         ready_at   = NEVER;
  int         rr         = 0;
  int         lu_left    = 0;
  int         b_from     = NEVER;
  int         b_to       = NEVER;
  bit         lu_prev    = 1'b0;
  int         req_mode   = 0;
  int         alive_mode = 0;
  int         b_mode     = 0;
  int         lvl_mode   = 0;
  int         lu_mode    = 0;
  bit         spur_en    = 1'b0;
  logic [4:0] req_fix    = 5'b00001;
  logic [4:0] alive_fix  = 5'b11111;
  int         lvl_ptr    = 0;
  logic [3:0] lvl_list [5] = '{4'd1, 4'd3, 4'd5, 4'd9, 4'd0};

  task automatic step();
    logic [4:0] el;
    int idx;
    int g;
    int d;
    int f;
    bit busy;
    @(negedge pclk);
    check("armed", int'(bus.armed), (cyc >= ready_at) ? 1 : 0);
    if (lu_left == 0 && !lu_prev) begin
      if (lu_mode == 1 && cyc == b_from + 1) lu_left = 10;
      else if (lu_mode == 2 && $urandom_range(0, 59) == 0)
        lu_left = $urandom_range(3, 10);
    end
    if (lu_left > 0) begin
      level_up = 1'b1;
      lu_left--;
      ready_at = NEVER;
      rr = 0;
    end else begin
      level_up = 1'b0;
      if (lu_prev) ready_at = cyc + 1 + cd_of(level);
    end
    bus.fire_req = (req_mode == 0) ? req_fix : 5'($urandom);
    if (alive_mode == 0) bus.alive = alive_fix;
    else bus.alive = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    busy = (cyc >= b_from && cyc <= b_to);
    if (!busy && spur_en && cyc >= ready_at && $urandom_range(0, 2) == 0)
      busy = 1'b1;
    bus.bullet_busy = busy;
    el = bus.fire_req & bus.alive;
    if (!level_up && cyc >= ready_at && el != '0 && !busy) begin
      idx = pick(el, rr);
      g = cyc + 1;
      sb.push_back('{g, idx});
      rr = (idx + 1) % N_EN;
      if (lvl_mode == 1) begin
        level = lvl_list[lvl_ptr[2:0]];
        lvl_ptr = (lvl_ptr + 1) % 5;
      end else if (lvl_mode == 2) begin
        level = 4'($urandom);
      end
      if (b_mode == 2 || (b_mode == 1 && $urandom_range(0, 3) == 0)) begin
        b_from = NEVER;
        b_to = NEVER;
        ready_at = g + AT + cd_of(level);
      end else begin
        d = (b_mode == 0) ? 1 : $urandom_range(1, AT - 1);
        f = (b_mode == 0) ? 3 : $urandom_range(1, 4);
        b_from = g + d;
        b_to = g + d + f - 1;
        ready_at = g + d + f + 1 + cd_of(level);
      end
    end
    lu_prev = level_up;
  endtask

  task automatic release_reset();
    @(negedge pclk);
    sb.delete();
    exp_gid = 0;
    rr = 0;
    lu_left = 0;
    lu_prev = 1'b0;
    level_up = 1'b0;
    b_from = NEVER;
    b_to = NEVER;
    bus.bullet_busy = 1'b0;
    rst_n = 1'b1;
    ready_at = cyc + CB;
  endtask

  bit found;

  initial begin
    bus.fire_req = '0;
    bus.alive = '1;
    bus.bullet_busy = 1'b0;
    repeat (3) @(negedge pclk);
    check("rst_grant", int'(bus.fire_grant), 0);
    check("rst_gid", int'(bus.grant_id), 0);
    check("rst_armed", int'(bus.armed), 0);
    release_reset();

    req_fix = 5'b00001;
    repeat (150) step();
    req_fix = 5'b11111;
    repeat (170) step();
    alive_fix = 5'b10101;
    repeat (120) step();

    alive_fix = 5'b11111;
    b_mode = 2;
    lvl_mode = 1;
    spur_en = 1'b1;
    repeat (250) step();

    b_mode = 0;
    lvl_mode = 0;
    spur_en = 1'b0;
    lu_mode = 1;
    req_fix = 5'b10110;
    repeat (200) step();

    req_mode = 1;
    alive_mode = 1;
    b_mode = 1;
    lvl_mode = 2;
    lu_mode = 2;
    spur_en = 1'b1;
    repeat (2500) step();

    req_mode = 0;
    alive_mode = 0;
    b_mode = 0;
    lvl_mode = 0;
    lu_mode = 0;
    spur_en = 1'b0;
    req_fix = 5'b11111;
    alive_fix = 5'b00000;
    repeat (80) step();

    alive_fix = 5'b11111;
    level = 4'd9;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (bus.fire_grant != '0) found = 1'b1;
    end
    check("grant_before_reset", int'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_clr_grant", int'(bus.fire_grant), 0);
    check("async_clr_gid", int'(bus.grant_id), 0);
    check("async_clr_armed", int'(bus.armed), 0);
    repeat (2) @(negedge pclk);
    release_reset();
    repeat (80) step();

    bus.fire_req = '0;
    repeat (3) @(negedge pclk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
